// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default special instruction words and address-width helper.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } ifu_state_t;

  localparam int unsigned IMEM_DEPTH_DEF = 256;
  localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_sp_ram.sv
// Word-addressed instruction memory: synchronous write port, asynchronous
// (combinational) read port.
module imem_sp_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; a loaded program must survive a warm reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program loader, PC, instruction memory and IF/ID register,
// sequenced by a LOAD/RUN/HALTED state machine with stall, jump and single-step.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned      NBITS      = 32,
  parameter int unsigned      IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter logic [NBITS-1:0] RESET_PC   = '0,
  parameter logic [NBITS-1:0] HALT_WORD  = HALT_WORD_DEF,
  parameter logic [NBITS-1:0] NOP_WORD   = NOP_WORD_DEF,
  parameter int unsigned      ADDR_W     = addr_w(IMEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic [NBITS-1:0]  i_load_data,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_stall,
  input  logic              i_jump,
  input  logic [NBITS-1:0]  i_jump_pc,
  output logic [NBITS-1:0]  o_pc,
  output logic [NBITS-1:0]  o_instr,
  output logic [NBITS-1:0]  o_pc_plus4,
  output logic              o_valid,
  output logic [ADDR_W:0]   o_load_ptr,
  output logic [1:0]        o_state,
  output logic              o_halted
);

  localparam logic [ADDR_W:0]  PTR_MAX = (ADDR_W + 1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W + 1)'(1);
  localparam logic [NBITS-1:0] PC_STEP = NBITS'(4);

  ifu_state_t       r_state;
  logic [NBITS-1:0] r_pc;
  logic [NBITS-1:0] r_instr;
  logic [NBITS-1:0] r_pc_plus4;
  logic             r_valid;
  logic [ADDR_W:0]  r_load_ptr;

  logic             w_we;
  logic [NBITS-1:0] w_fetch;
  logic [NBITS-1:0] w_pc_next;
  logic             w_advance;

  // Writes beyond the last word are dropped; the pointer saturates at depth.
  assign w_we      = !i_rst && (r_state == ST_LOAD) && i_load_en && (r_load_ptr < PTR_MAX);
  assign w_pc_next = r_pc + PC_STEP;
  assign w_advance = !i_stall && (!i_step_mode || i_step);

  imem_sp_ram #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (NBITS),
    .ADDR_W(ADDR_W)
  ) u_imem (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_waddr(r_load_ptr[ADDR_W-1:0]),
    .i_wdata(i_load_data),
    .i_raddr(r_pc[ADDR_W+1:2]),
    .o_rdata(w_fetch)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_LOAD;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_load_ptr <= '0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (w_we) r_load_ptr <= r_load_ptr + PTR_ONE;
          if (i_start) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
          end
        end
        ST_RUN: begin
          // Jump outranks stall and step gating; a halt fetched alongside it is discarded.
          if (i_jump) begin
            r_pc       <= i_jump_pc;
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
          end else if (w_advance) begin
            r_instr    <= w_fetch;
            r_pc_plus4 <= w_pc_next;
            r_valid    <= 1'b1;
            if (w_fetch == HALT_WORD) r_state <= ST_HALTED;
            else                      r_pc    <= w_pc_next;
          end
        end
        ST_HALTED: begin
          r_instr    <= NOP_WORD;
          r_pc_plus4 <= '0;
          r_valid    <= 1'b0;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign o_pc       = r_pc;
  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;
  assign o_load_ptr = r_load_ptr;
  assign o_state    = r_state;
  assign o_halted   = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with literal
// expectations plus a randomized phase, all checked against a behavioural model.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 256;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, load_en, start, step_mode, step, stall, jump;
  logic [31:0] load_data, jump_pc;
  logic [31:0] pc, instr, pc_plus4;
  logic        valid, halted;
  logic [8:0]  load_ptr;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load_en  (load_en),
    .i_load_data(load_data),
    .i_start    (start),
    .i_step_mode(step_mode),
    .i_step     (step),
    .i_stall    (stall),
    .i_jump     (jump),
    .i_jump_pc  (jump_pc),
    .o_pc       (pc),
    .o_instr    (instr),
    .o_pc_plus4 (pc_plus4),
    .o_valid    (valid),
    .o_load_ptr (load_ptr),
    .o_state    (state),
    .o_halted   (halted)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the fetch stage must show after each edge.
  int          m_state;
  logic [31:0] m_pc, m_instr, m_pc_plus4;
  bit          m_valid, m_instr_known;
  int          m_ptr;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_pc = 32'd0; m_instr = NOP; m_instr_known = 1'b1;
      m_pc_plus4 = 32'd0; m_valid = 1'b0; m_ptr = 0;
    end else if (m_state == 0) begin
      if (load_en && m_ptr < DEPTH) begin
        m_mem[m_ptr] = load_data;
        m_known[m_ptr] = 1'b1;
        m_ptr = m_ptr + 1;
      end
      if (start) begin
        m_state = 1;
        m_pc = 32'd0;
      end
    end else if (m_state == 1) begin
      if (jump) begin
        m_pc = jump_pc; m_instr = NOP; m_instr_known = 1'b1; m_valid = 1'b0;
      end else if (!stall && (!step_mode || step)) begin
        int idx;
        idx = int'((m_pc / 4) % DEPTH);
        m_instr = m_mem[idx];
        m_instr_known = m_known[idx];
        m_pc_plus4 = m_pc + 32'd4;
        m_valid = 1'b1;
        if (m_known[idx] && m_mem[idx] == HALT) m_state = 2;
        else m_pc = m_pc + 32'd4;
      end
    end else begin
      m_instr = NOP; m_instr_known = 1'b1; m_valid = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state",    32'(state),    32'(m_state));
      check("halted",   32'(halted),   32'(m_state == 2));
      check("pc",       pc,            m_pc);
      check("valid",    32'(valid),    32'(m_valid));
      check("load_ptr", 32'(load_ptr), 32'(m_ptr));
      if (m_instr_known) check("instr", instr, m_instr);
      if (m_valid) check("pc_plus4", pc_plus4, m_pc_plus4);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; load_en = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    stall = 1'b0; jump = 1'b0; load_data = 32'd0; jump_pc = 32'd0;
  endtask

  logic [31:0] prog4 [4] = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'hFFFF_FFFF};
  logic [31:0] full_w [DEPTH + 2];

  // Runs the 4-word program from PC 0 (already in RUN) with a 2-cycle stall at PC 8.
  task automatic run_prog4();
    tick();
    check("p4_i0", instr, 32'h2001_0005); check("p4_p0", pc_plus4, 32'd4);
    tick();
    check("p4_i1", instr, 32'h2002_0003); check("p4_p1", pc_plus4, 32'd8);
    check("p4_pc8", pc, 32'd8);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_pc", pc, 32'd8);
      check("stall_instr", instr, 32'h2002_0003);
      check("stall_valid", 32'(valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("p4_i2", instr, 32'h0022_1820); check("p4_p2", pc_plus4, 32'd12);
    tick();
    check("p4_i3", instr, 32'hFFFF_FFFF); check("p4_p3", pc_plus4, 32'd16);
    check("p4_halted", 32'(halted), 32'd1);
    tick();
    check("halt_pc", pc, 32'd12); check("halt_valid", 32'(valid), 32'd0);
    check("halt_instr", instr, NOP); check("halt_state", 32'(state), 32'd2);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    check("rst_state", 32'(state), 32'd0); check("rst_pc", pc, 32'd0);
    check("rst_instr", instr, NOP); check("rst_valid", 32'(valid), 32'd0);
    check("rst_pcp4", pc_plus4, 32'd0); check("rst_ptr", 32'(load_ptr), 32'd0);

    // Program load; last word written together with start.
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_data = prog4[i]; start = (i == 3);
      tick();
    end
    load_en = 1'b0; start = 1'b0;
    check("ld_ptr4", 32'(load_ptr), 32'd4); check("ld_run", 32'(state), 32'd1);
    check("ld_pc0", pc, 32'd0);
    run_prog4();
    repeat (3) tick();
    check("halt_frozen_pc", pc, 32'd12);

    // Reset from HALTED, rerun the retained program without reloading.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rh_state", 32'(state), 32'd0); check("rh_pc", pc, 32'd0);
    check("rh_valid", 32'(valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_prog4();

    // Overfill memory: writes past the last word must be dropped.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      full_w[i] = $urandom();
      if (full_w[i] == HALT) full_w[i] = 32'h1234_5678;
    end
    full_w[100] = HALT;
    full_w[DEPTH] = ~full_w[0];
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_en = 1'b1; load_data = full_w[i];
      tick();
    end
    load_en = 1'b0;
    check("ptr_sat", 32'(load_ptr), 32'(DEPTH));
    start = 1'b1;
    tick();
    start = 1'b0;

    // Jump together with stall: jump wins and flushes IF/ID.
    jump = 1'b1; jump_pc = 32'h40; stall = 1'b1;
    tick();
    jump = 1'b0; stall = 1'b0;
    check("jmp_pc", pc, 32'h40); check("jmp_instr", instr, NOP);
    check("jmp_valid", 32'(valid), 32'd0);
    tick();
    check("jmp_fetch", instr, full_w[16]); check("jmp_pc2", pc, 32'h44);

    // Wrap: PC = DEPTH*4 indexes word 0, which the overflow writes left intact.
    jump = 1'b1; jump_pc = 32'h3FC;
    tick();
    jump = 1'b0;
    tick();
    check("wrap_last", instr, full_w[255]); check("wrap_pc", pc, 32'h400);
    tick();
    check("wrap_first", instr, full_w[0]); check("wrap_pcp4", pc_plus4, 32'h404);

    // Step mode: jump overrides gating, then PC moves only on step pulses.
    step_mode = 1'b1; jump = 1'b1; jump_pc = 32'd0;
    tick();
    jump = 1'b0;
    repeat (5) begin
      tick();
      check("step_hold", pc, 32'd0);
    end
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      tick();
      check("step_pc", pc, 32'(4 * k));
      step = 1'b0;
      tick();
      check("step_gap", pc, 32'(4 * k));
    end
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    check("step_long", pc, 32'd24); check("step_long_instr", instr, full_w[5]);
    step_mode = 1'b0;

    // Randomized phase, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0) || (m_state == 2 && $urandom_range(0, 5) == 0);
      load_en   = ($urandom_range(0, 1) == 1);
      load_data = ($urandom_range(0, 15) == 0) ? HALT : $urandom();
      start     = ($urandom_range(0, 7) == 0);
      step_mode = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 1) == 1);
      stall     = ($urandom_range(0, 3) == 0);
      jump      = ($urandom_range(0, 9) == 0);
      jump_pc   = $urandom();
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
